// File: rtl/fir_sample_ctrl_if.sv
// Control bundle between the FIR sequencer and its upstream/datapath neighbours.
interface fir_sample_ctrl_if #(
  parameter int unsigned REG_W = 4
);
  logic             data_ready;
  logic             load_coeff;
  logic             overflow;
  logic             cnt_done;
  logic             modwait;
  logic             cnt_up;
  logic             clear;
  logic             err;
  logic [2:0]       op;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic [REG_W-1:0] dest;

  // Upstream, datapath and counter side
  modport master (
    output data_ready, load_coeff, overflow, cnt_done,
    input  modwait, cnt_up, clear, err, op, src1, src2, dest
  );

  // Sequencer side
  modport slave (
    input  data_ready, load_coeff, overflow, cnt_done,
    output modwait, cnt_up, clear, err, op, src1, src2, dest
  );
endinterface

// File: rtl/fir_sample_ctrl.sv
// FIR sequencer: shifts the sample window, stores a new sample, runs NUM_TAPS MAC steps,
// and loads coefficients one per request. Outputs are flops loaded from the next-state decode.
module fir_sample_ctrl #(
  parameter int unsigned NUM_TAPS = 4,
  parameter int unsigned REG_W    = 4
) (
  input logic              clk,
  input logic              rst,
  fir_sample_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_TAPS) + 1;

  localparam logic [REG_W-1:0] R_ACC      = '0;
  localparam logic [REG_W-1:0] R_NEW      = REG_W'(1);
  localparam logic [REG_W-1:0] R_TMP      = REG_W'(2 * NUM_TAPS + 1);
  localparam logic [REG_W-1:0] R_COEF0    = REG_W'(NUM_TAPS + 1);
  localparam logic [REG_W-1:0] R_TAPS     = REG_W'(NUM_TAPS);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_TAPS);
  localparam logic [IDX_W-1:0] COEFF_LAST = IDX_W'(NUM_TAPS - 1);

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_COPY    = 3'b001;
  localparam logic [2:0] OP_LD_SAMP = 3'b010;
  localparam logic [2:0] OP_LD_COEF = 3'b011;
  localparam logic [2:0] OP_ADD     = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_COEFF, S_SHIFT, S_STORE, S_MUL, S_ACC, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] tap_q, tap_d;
  logic [IDX_W-1:0] coeff_q, coeff_d;

  logic             modwait_d, cnt_up_d, clear_d, err_d;
  logic [2:0]       op_d;
  logic [REG_W-1:0] src1_d, src2_d, dest_d;
  logic             arith_c;

  // State, indices and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      coeff_q     <= '0;
      bus.modwait <= 1'b0;
      bus.cnt_up  <= 1'b0;
      bus.clear   <= 1'b0;
      bus.err     <= 1'b0;
      bus.op      <= OP_NOP;
      bus.src1    <= '0;
      bus.src2    <= '0;
      bus.dest    <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      coeff_q     <= coeff_d;
      bus.modwait <= modwait_d;
      bus.cnt_up  <= cnt_up_d;
      bus.clear   <= clear_d;
      bus.err     <= err_d;
      bus.op      <= op_d;
      bus.src1    <= src1_d;
      bus.src2    <= src2_d;
      bus.dest    <= dest_d;
    end
  end

  // Next state, then the outputs that state will present
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    coeff_d   = coeff_q;
    op_d      = OP_NOP;
    src1_d    = '0;
    src2_d    = '0;
    dest_d    = '0;
    modwait_d = 1'b0;
    cnt_up_d  = 1'b0;
    clear_d   = 1'b0;
    err_d     = 1'b0;
    arith_c   = (state_q == S_MUL) || ((state_q == S_ACC) && (tap_q != IDX_ONE));

    case (state_q)
      S_IDLE, S_ERR: begin
        if (bus.data_ready) begin
          state_d = S_SHIFT;
          tap_d   = COEFF_LAST;
        end else if (bus.load_coeff) begin
          state_d = S_COEFF;
        end
      end
      S_COEFF: begin
        state_d = S_IDLE;
        coeff_d = (coeff_q == COEFF_LAST) ? '0 : coeff_q + IDX_ONE;
      end
      S_SHIFT: begin
        // The sample must still be valid when the store would be issued
        if (tap_q != IDX_ONE)     tap_d   = tap_q - IDX_ONE;
        else if (bus.data_ready)  state_d = S_STORE;
        else                      state_d = S_ERR;
      end
      S_STORE: begin
        state_d = S_MUL;
        tap_d   = IDX_ONE;
      end
      S_MUL: state_d = (arith_c && bus.overflow) ? S_ERR : S_ACC;
      S_ACC: begin
        if (arith_c && bus.overflow) state_d = S_ERR;
        else if (tap_q == IDX_LAST)  state_d = S_DONE;
        else begin
          state_d = S_MUL;
          tap_d   = tap_q + IDX_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_COEFF: begin
        op_d      = OP_LD_COEF;
        dest_d    = R_COEF0 + REG_W'(coeff_q);
        modwait_d = 1'b1;
        clear_d   = (coeff_q == COEFF_LAST);
      end
      S_SHIFT: begin
        op_d      = OP_COPY;
        src1_d    = REG_W'(tap_d);
        dest_d    = REG_W'(tap_d) + R_NEW;
        modwait_d = 1'b1;
      end
      S_STORE: begin
        op_d      = OP_LD_SAMP;
        dest_d    = R_NEW;
        modwait_d = 1'b1;
        cnt_up_d  = 1'b1;
      end
      S_MUL: begin
        op_d      = OP_MUL;
        src1_d    = REG_W'(tap_d);
        src2_d    = R_TAPS + REG_W'(tap_d);
        dest_d    = R_TMP;
        modwait_d = 1'b1;
      end
      S_ACC: begin
        modwait_d = 1'b1;
        dest_d    = R_ACC;
        if (tap_d == IDX_ONE) begin
          op_d   = OP_COPY;
          src1_d = R_TMP;
        end else begin
          op_d   = OP_ADD;
          src1_d = R_ACC;
          src2_d = R_TMP;
        end
      end
      S_DONE:  clear_d = bus.cnt_done;
      S_ERR:   err_d   = 1'b1;
      default: ;
    endcase
  end
endmodule
